superscalar_hazard_unit: RTL and testbench

Parametrised in-order hazard unit for the superscalar pipeline, generalising the scalar MIPS hazard unit to LANES issue slots with a latency-counting register scoreboard. It sits between Decode and Execute. Each cycle it decides which lanes of the decode group may issue, and it splits a group across cycles when there is an intra-group dependency. It generates StallF/StallD/FlushE equivalents and tracks multi-cycle producers (loads, mul/div) so that no source is read before it can be forwarded.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_bank.sv | 62 ++++++
 rtl/superscalar_hazard_unit.sv | 155 +++++++++++++++
 tb/tb_superscalar_hazard_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: default geometry, shared types and the latency helper used by
// the superscalar hazard unit and its scoreboard bank.
package hazard_pkg;

    localparam int DEFAULT_LANES  = 2;
    localparam int DEFAULT_NREG   = 32;
    localparam int DEFAULT_REGW   = 5;
    localparam int DEFAULT_MAXLAT = 8;
    localparam int DEFAULT_LATW   = $clog2(DEFAULT_MAXLAT + 1);

    typedef logic [DEFAULT_REGW-1:0] reg_idx_t;
    typedef logic [DEFAULT_LATW-1:0] lat_t;

    // Producer latency to scoreboard preload: a latency of 0 behaves like 1,
    // and an ALU result (latency 1) is forwardable on the very next cycle.
    function automatic int lat_to_count(input int lat);
        return (lat < 1) ? 0 : lat - 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_bank.sv
// hazard_scoreboard_bank: one down-counter per architectural register giving
// the cycles left until that register's pending value can be forwarded.
// LANES write ports preload counters for issuing producers; 2*LANES read
// ports report whether each requested source is ready.
module hazard_scoreboard_bank
    import hazard_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int NREG  = DEFAULT_NREG,
    parameter int REGW  = DEFAULT_REGW,
    parameter int LATW  = DEFAULT_LATW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        wr_en,
    input  logic [LANES*REGW-1:0]   wr_idx,
    input  logic [LANES*LATW-1:0]   wr_cnt,
    input  logic [2*LANES*REGW-1:0] rd_idx,
    output logic [2*LANES-1:0]      rd_ready
);

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];

    // Age every live counter by one cycle, then let issuing producers reload theirs.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LATW'(1) : '0;
            for (int l = 0; l < LANES; l++) begin
                if (wr_en[l] && (r != 0) && (int'(wr_idx[l*REGW +: REGW]) == r)) begin
                    cnt_d[r] = wr_cnt[l*LATW +: LATW];
                end
            end
        end
    end

    // Counter storage; r0 is never written so it stays at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // A source is ready when it is r0, lies outside the file, or its counter has drained.
    always_comb begin
        rd_ready = '0;
        for (int k = 0; k < 2*LANES; k++) begin
            if ((rd_idx[k*REGW +: REGW] == '0) || (int'(rd_idx[k*REGW +: REGW]) >= NREG)) begin
                rd_ready[k] = 1'b1;
            end else begin
                rd_ready[k] = (cnt_q[rd_idx[k*REGW +: REGW]] == '0);
            end
        end
    end

endmodule

// File: rtl/superscalar_hazard_unit.sv
// superscalar_hazard_unit: in-order issue control between Decode and Execute
// for a LANES-wide decode group. Decides per lane whether it issues this
// cycle, splits a group across cycles on intra-group RAW/WAW, and holds
// consumers of multi-cycle producers via a latency-counting scoreboard.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cycles and
// split_groups counters.
module superscalar_hazard_unit
    import hazard_pkg::*;
#(
    parameter int LANES  = DEFAULT_LANES,
    parameter int NREG   = DEFAULT_NREG,
    parameter int REGW   = DEFAULT_REGW,
    parameter int MAXLAT = DEFAULT_MAXLAT,
    parameter int LATW   = $clog2(MAXLAT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES-1:0]      valid_d,
    input  logic [LANES*REGW-1:0] rs_d,
    input  logic [LANES*REGW-1:0] rt_d,
    input  logic [LANES*REGW-1:0] dst_d,
    input  logic [LANES-1:0]      wen_d,
    input  logic [LANES*LATW-1:0] lat_d,
    input  logic                  flush,
    output logic [LANES-1:0]      issue_go,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic [LANES-1:0]      flush_e
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           split_groups
`endif
);

    logic [LANES-1:0]          done_q;
    logic [LANES-1:0]          eligible;
    logic [LANES-1:0]          go;
    logic [LANES-1:0]          pending;
    logic                      stall;
    logic [2*LANES*REGW-1:0]   rd_idx;
    logic [2*LANES-1:0]        rd_ready;
    logic [LANES-1:0]          wr_en;
    logic [LANES*LATW-1:0]     wr_cnt;

    // Present both sources of every lane to the scoreboard: rs on port 2i, rt on 2i+1.
    always_comb begin
        rd_idx = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_idx[(2*i)*REGW   +: REGW] = rs_d[i*REGW +: REGW];
            rd_idx[(2*i+1)*REGW +: REGW] = rt_d[i*REGW +: REGW];
        end
    end

    hazard_scoreboard_bank #(
        .LANES (LANES),
        .NREG  (NREG),
        .REGW  (REGW),
        .LATW  (LATW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (dst_d),
        .wr_cnt   (wr_cnt),
        .rd_idx   (rd_idx),
        .rd_ready (rd_ready)
    );

    // A lane is eligible when pending, its sources are ready and no earlier eligible lane feeds or overwrites it.
    always_comb begin : elig_calc
        logic [LANES-1:0] e;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            e[i] = valid_d[i] & ~done_q[i] & rd_ready[2*i] & rd_ready[2*i+1];
            for (int j = 0; j < i; j++) begin
                if (e[j] && wen_d[j] && (dst_d[j*REGW +: REGW] != '0)) begin
                    if ((dst_d[j*REGW +: REGW] == rs_d[i*REGW +: REGW]) ||
                        (dst_d[j*REGW +: REGW] == rt_d[i*REGW +: REGW]) ||
                        (wen_d[i] && (dst_d[j*REGW +: REGW] == dst_d[i*REGW +: REGW]))) begin
                        e[i] = 1'b0;
                    end
                end
            end
        end
        eligible = e;
    end

    // In-order issue: already-issued and empty lanes are transparent, the first blocked lane blocks the rest.
    always_comb begin : issue_chain
        logic chain;
        go    = '0;
        chain = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (valid_d[i] && !done_q[i]) begin
                go[i] = chain & eligible[i];
                chain = go[i];
            end
        end
        if (!reset || flush) begin
            go = '0;
        end
    end

    assign pending  = valid_d & ~done_q & ~go;
    assign stall    = (|pending) & ~flush & reset;
    assign issue_go = go;
    assign stall_f  = stall;
    assign stall_d  = stall;
    assign flush_e  = ~go | {LANES{flush}};

    // Issuing writers preload their destination counter with latency-1; r0 writes are dropped.
    always_comb begin
        wr_en  = '0;
        wr_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_en[i] = go[i] & wen_d[i] & (dst_d[i*REGW +: REGW] != '0);
            wr_cnt[i*LATW +: LATW] = LATW'(lat_to_count(int'(lat_d[i*LATW +: LATW])));
        end
    end

    // Remember lanes issued from a partially issued group; forget them once the group completes or is flushed.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            done_q <= '0;
        end else if (stall) begin
            done_q <= done_q | go;
        end else begin
            done_q <= '0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic split_start;

    // A group splits when its first issue cycle leaves some lane behind.
    assign split_start = stall & (done_q == '0) & (|go);

    // Saturating counters for stalled cycles and split groups.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            split_groups <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (split_start && (split_groups != '1)) begin
                split_groups <= split_groups + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_superscalar_hazard_unit.sv
// tb_superscalar_hazard_unit: directed scenarios for the load-use, split,
// long-latency, r0, flush and reset cases, followed by a randomized run
// against an absolute-time scoreboard model (build macro HAZARD_STATS_EN
// also checks the statistics counters).
module tb_superscalar_hazard_unit;
    import hazard_pkg::*;

    localparam int LANES  = DEFAULT_LANES;
    localparam int NREG   = DEFAULT_NREG;
    localparam int REGW   = DEFAULT_REGW;
    localparam int MAXLAT = DEFAULT_MAXLAT;
    localparam int LATW   = DEFAULT_LATW;

    logic                  clk;
    logic                  reset;
    logic [LANES-1:0]      valid_d;
    logic [LANES*REGW-1:0] rs_d;
    logic [LANES*REGW-1:0] rt_d;
    logic [LANES*REGW-1:0] dst_d;
    logic [LANES-1:0]      wen_d;
    logic [LANES*LATW-1:0] lat_d;
    logic                  flush;
    logic [LANES-1:0]      issue_go;
    logic                  stall_f;
    logic                  stall_d;
    logic [LANES-1:0]      flush_e;
`ifdef HAZARD_STATS_EN
    logic [31:0]           stall_cycles;
    logic [31:0]           split_groups;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: absolute cycle at which each register becomes forwardable.
    int               ready_at [NREG];
    int               m_cyc;
    logic [LANES-1:0] m_issued;
    logic [LANES-1:0] m_go;
    logic             m_stall;
    int               m_stalls;
    int               m_splits;

    superscalar_hazard_unit #(
        .LANES  (LANES),
        .NREG   (NREG),
        .REGW   (REGW),
        .MAXLAT (MAXLAT),
        .LATW   (LATW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_d  (valid_d),
        .rs_d     (rs_d),
        .rt_d     (rt_d),
        .dst_d    (dst_d),
        .wen_d    (wen_d),
        .lat_d    (lat_d),
        .flush    (flush),
        .issue_go (issue_go),
        .stall_f  (stall_f),
        .stall_d  (stall_d),
        .flush_e  (flush_e)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .split_groups (split_groups)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_lane(input int i, input logic v, input int rs, input int rt,
                            input int dst, input logic wen, input int lat);
        valid_d[i]              = v;
        rs_d[i*REGW +: REGW]    = reg_idx_t'(rs);
        rt_d[i*REGW +: REGW]    = reg_idx_t'(rt);
        dst_d[i*REGW +: REGW]   = reg_idx_t'(dst);
        wen_d[i]                = wen;
        lat_d[i*LATW +: LATW]   = lat_t'(lat);
    endtask

    task automatic clear_group();
        valid_d = '0;
        rs_d    = '0;
        rt_d    = '0;
        dst_d   = '0;
        wen_d   = '0;
        lat_d   = '0;
        flush   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int f_rs(input int i);
        return int'(rs_d[i*REGW +: REGW]);
    endfunction

    function automatic int f_rt(input int i);
        return int'(rt_d[i*REGW +: REGW]);
    endfunction

    function automatic int f_dst(input int i);
        return int'(dst_d[i*REGW +: REGW]);
    endfunction

    function automatic int f_lat(input int i);
        return int'(lat_d[i*LATW +: LATW]);
    endfunction

    function automatic logic src_ready(input int r);
        return (r == 0) || (m_cyc >= ready_at[r]);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        set_lane(0, 1'b1, 2, 3, 1, 1'b1, 1);
        set_lane(1, 1'b1, 4, 5, 6, 1'b1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b00 || stall_d !== 1'b0 || stall_f !== 1'b0 || flush_e !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_state: go=%b stall_f=%b stall_d=%b fe=%b, expected go=00 stall=0 fe=11",
                     issue_go, stall_f, stall_d, flush_e);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b11 || stall_d !== 1'b0 || stall_f !== 1'b0 || flush_e !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_release: go=%b stall_d=%b fe=%b, expected go=11 stall=0 fe=00",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        clear_group();
    endtask

    task automatic test_load_use();
        set_lane(0, 1'b1, 2, 0, 8, 1'b1, 2);
        set_lane(1, 1'b1, 8, 1, 9, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b01 || stall_d !== 1'b1 || stall_f !== 1'b1 || flush_e !== 2'b10) begin
            errors++;
            $display("[TB] FAIL load_use_c0: go=%b stall_d=%b fe=%b, expected go=01 stall=1 fe=10",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b00 || stall_d !== 1'b1 || flush_e !== 2'b11) begin
            errors++;
            $display("[TB] FAIL load_use_c1: go=%b stall_d=%b fe=%b, expected go=00 stall=1 fe=11",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b10 || stall_d !== 1'b0 || flush_e !== 2'b01) begin
            errors++;
            $display("[TB] FAIL load_use_c2: go=%b stall_d=%b fe=%b, expected go=10 stall=0 fe=01",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        clear_group();
    endtask

    task automatic test_intra_group();
        set_lane(0, 1'b1, 1, 2, 3, 1'b1, 1);
        set_lane(1, 1'b1, 3, 5, 4, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b01 || stall_d !== 1'b1) begin
            errors++;
            $display("[TB] FAIL intra_c0: go=%b stall_d=%b, expected go=01 stall=1", issue_go, stall_d);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b10 || stall_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL intra_c1: go=%b stall_d=%b, expected go=10 stall=0", issue_go, stall_d);
        end
`ifdef HAZARD_STATS_EN
        // Since reset: load-use split + this split; 2 load-use stalls + 1 here.
        checks++;
        if (split_groups !== 32'd2 || stall_cycles !== 32'd3) begin
            errors++;
            $display("[TB] FAIL stats_directed: split=%0d stalls=%0d, expected split=2 stalls=3",
                     split_groups, stall_cycles);
        end
`endif
        next_cycle();
        clear_group();
    endtask

    task automatic test_long_latency();
        set_lane(0, 1'b1, 1, 2, 7, 1'b1, 5);
        set_lane(1, 1'b0, 0, 0, 0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b01 || stall_d !== 1'b0 || flush_e !== 2'b10) begin
            errors++;
            $display("[TB] FAIL long_producer: go=%b stall_d=%b fe=%b, expected go=01 stall=0 fe=10",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        set_lane(0, 1'b1, 7, 0, 10, 1'b1, 1);
        set_lane(1, 1'b1, 1, 2, 11, 1'b1, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (issue_go !== 2'b00 || stall_d !== 1'b1 || flush_e !== 2'b11) begin
                errors++;
                $display("[TB] FAIL long_stall_%0d: go=%b stall_d=%b fe=%b, expected go=00 stall=1 fe=11",
                         k, issue_go, stall_d, flush_e);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b11 || stall_d !== 1'b0 || flush_e !== 2'b00) begin
            errors++;
            $display("[TB] FAIL long_consume: go=%b stall_d=%b fe=%b, expected go=11 stall=0 fe=00",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        clear_group();
    endtask

    task automatic test_r0();
        set_lane(0, 1'b1, 0, 0, 0, 1'b1, 3);
        set_lane(1, 1'b1, 0, 0, 0, 1'b1, 4);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b11 || stall_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_group: go=%b stall_d=%b, expected go=11 stall=0", issue_go, stall_d);
        end
        next_cycle();
        set_lane(0, 1'b1, 0, 0, 5, 1'b1, 1);
        set_lane(1, 1'b1, 0, 0, 0, 1'b1, 2);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b11 || stall_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_reader: go=%b stall_d=%b, expected go=11 stall=0", issue_go, stall_d);
        end
        next_cycle();
        clear_group();
    endtask

    task automatic test_flush_mid_split();
        set_lane(0, 1'b1, 1, 2, 12, 1'b1, 1);
        set_lane(1, 1'b1, 12, 0, 13, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b01 || stall_d !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_pre: go=%b stall_d=%b, expected go=01 stall=1", issue_go, stall_d);
        end
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b00 || stall_d !== 1'b0 || stall_f !== 1'b0 || flush_e !== 2'b11) begin
            errors++;
            $display("[TB] FAIL flush_cycle: go=%b stall_f=%b stall_d=%b fe=%b, expected go=00 stall=0 fe=11",
                     issue_go, stall_f, stall_d, flush_e);
        end
        next_cycle();
        flush = 1'b0;
        set_lane(0, 1'b1, 12, 2, 14, 1'b1, 1);
        set_lane(1, 1'b1, 1, 2, 16, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b11 || stall_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_fresh: go=%b stall_d=%b, expected go=11 stall=0", issue_go, stall_d);
        end
        next_cycle();
        clear_group();
    endtask

    task automatic test_reset_mid_split();
        set_lane(0, 1'b1, 1, 2, 15, 1'b1, 8);
        set_lane(1, 1'b1, 15, 0, 17, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b01 || stall_d !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_pre: go=%b stall_d=%b, expected go=01 stall=1", issue_go, stall_d);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b00 || stall_d !== 1'b0 || flush_e !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rst_mid_hold: go=%b stall_d=%b fe=%b, expected go=00 stall=0 fe=11",
                     issue_go, stall_d, flush_e);
        end
        next_cycle();
        reset = 1'b1;
        set_lane(0, 1'b1, 15, 0, 18, 1'b1, 1);
        set_lane(1, 1'b1, 2, 3, 19, 1'b1, 1);
        @(negedge clk);
        checks++;
        if (issue_go !== 2'b11 || stall_d !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_fresh: go=%b stall_d=%b, expected go=11 stall=0", issue_go, stall_d);
        end
        next_cycle();
        clear_group();
    endtask

    task automatic test_random();
        logic             need_new;
        logic             chain;
        logic             ok;
        logic [LANES-1:0] exp_fe;
        int               nv;
        int               lat;

        clear_group();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            ready_at[r] = 0;
        end
        m_cyc    = 0;
        m_issued = '0;
        m_stalls = 0;
        m_splits = 0;
        need_new = 1'b1;

        for (int n = 0; n < 600; n++) begin
            if (need_new) begin
                nv = $urandom_range(0, LANES);
                for (int i = 0; i < LANES; i++) begin
                    lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXLAT) : $urandom_range(1, 2);
                    set_lane(i, (i < nv), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), ($urandom_range(0, 3) != 0), lat);
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            @(negedge clk);

            m_go  = '0;
            chain = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (valid_d[i] && !m_issued[i]) begin
                    ok = chain && !flush && src_ready(f_rs(i)) && src_ready(f_rt(i));
                    for (int j = 0; j < i; j++) begin
                        if (m_go[j] && wen_d[j] && f_dst(j) != 0 &&
                            (f_dst(j) == f_rs(i) || f_dst(j) == f_rt(i) ||
                             (wen_d[i] && f_dst(j) == f_dst(i)))) begin
                            ok = 1'b0;
                        end
                    end
                    m_go[i] = ok;
                    chain   = ok;
                end
            end
            m_stall = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (valid_d[i] && !m_issued[i] && !m_go[i]) m_stall = 1'b1;
            end
            if (flush) m_stall = 1'b0;
            exp_fe = ~m_go | {LANES{flush}};

            checks++;
            if (issue_go !== m_go || stall_d !== m_stall || stall_f !== m_stall || flush_e !== exp_fe) begin
                errors++;
                $display("[TB] FAIL random_cycle_%0d: go=%b stall_f=%b stall_d=%b fe=%b, expected go=%b stall=%b fe=%b",
                         n, issue_go, stall_f, stall_d, flush_e, m_go, m_stall, exp_fe);
            end

            for (int i = 0; i < LANES; i++) begin
                if (m_go[i] && wen_d[i] && f_dst(i) != 0) begin
                    ready_at[f_dst(i)] = m_cyc + ((f_lat(i) == 0) ? 1 : f_lat(i));
                end
            end
            if (m_stall) m_stalls++;
            if (m_stall && m_issued == '0 && m_go != '0) m_splits++;
            m_issued = (flush || !m_stall) ? '0 : (m_issued | m_go);
            m_cyc++;
            need_new = flush || !m_stall;
            next_cycle();
        end

`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cycles !== 32'(m_stalls) || split_groups !== 32'(m_splits)) begin
            errors++;
            $display("[TB] FAIL stats_random: stalls=%0d split=%0d, expected stalls=%0d split=%0d",
                     stall_cycles, split_groups, m_stalls, m_splits);
        end
`endif
        clear_group();
    endtask

    initial begin
        reset = 1'b0;
        clear_group();
        $display("[TB] starting superscalar_hazard_unit bench");
        test_reset();
        test_load_use();
        test_intra_group();
        test_long_latency();
        test_r0();
        test_flush_mid_split();
        test_reset_mid_split();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
